// File: rtl/sprite_move_scheduler_if.sv
// Bundle between the input/collision stages and the sprite move scheduler:
// direction requests and legal-move mask in, per-sprite step commands out.
interface sprite_move_scheduler_if;
  logic [3:0]  dir_req;
  logic        dir_req_valid;
  logic [15:0] ghost_dirs;
  logic [3:0]  valid_moves;
  logic [2:0]  which_sprite;
  logic [3:0]  move_direction;
  logic        step_valid;
  logic        frame_overrun;

  modport slave (
    input  dir_req, dir_req_valid, ghost_dirs, valid_moves,
    output which_sprite, move_direction, step_valid, frame_overrun
  );

  modport master (
    output dir_req, dir_req_valid, ghost_dirs, valid_moves,
    input  which_sprite, move_direction, step_valid, frame_overrun
  );
endinterface

// File: rtl/sprite_move_scheduler.sv
// Per-frame move scheduler: every STEP_DIV cycles it walks Pacman and the four ghosts,
// issuing one step_valid per sprite (3 cycles each). Optional pause input under `STEP_PAUSE_EN.
module sprite_move_scheduler #(
  parameter logic [23:0] STEP_DIV = 24'd2500000
) (
  input  logic clk,
  input  logic rst,
`ifdef STEP_PAUSE_EN
  input  logic pause,
`endif
  sprite_move_scheduler_if.slave bus
);

  typedef enum logic [1:0] {WAIT_TICK, SELECT, EVAL, ISSUE} state_t;

  state_t      state_q, state_d;
  logic [23:0] div_q, div_d;
  logic [2:0]  sprite_q, sprite_d;
  logic [3:0]  move_q, move_d;
  logic        overrun_q, overrun_d;
  logic [3:0]  cur_dir_q, cur_dir_d;
  logic [3:0]  buf_dir_q, buf_dir_d;
  logic        pause_w;
  logic        tick;
  logic [3:0]  ghost_slice;

`ifdef STEP_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  // A paused divider never reaches its terminal count, so no frame can start.
  assign tick = !pause_w && (div_q == STEP_DIV - 24'd1);

  always_comb begin
    ghost_slice = 4'b0000;
    case (sprite_q)
      3'd1:    ghost_slice = bus.ghost_dirs[3:0];
      3'd2:    ghost_slice = bus.ghost_dirs[7:4];
      3'd3:    ghost_slice = bus.ghost_dirs[11:8];
      3'd4:    ghost_slice = bus.ghost_dirs[15:12];
      default: ghost_slice = 4'b0000;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    sprite_d  = sprite_q;
    move_d    = move_q;
    overrun_d = overrun_q;
    cur_dir_d = cur_dir_q;
    buf_dir_d = buf_dir_q;

    if (!pause_w) begin
      div_d = tick ? 24'd0 : div_q + 24'd1;
    end

    case (state_q)
      WAIT_TICK: begin
        if (tick) begin
          state_d  = SELECT;
          sprite_d = 3'd0;
        end
      end
      SELECT: state_d = EVAL;
      EVAL: begin
        state_d = ISSUE;
        if (sprite_q == 3'd0) begin
          if ((buf_dir_q & bus.valid_moves) != 4'b0000) begin
            move_d    = buf_dir_q;
            cur_dir_d = buf_dir_q;
            buf_dir_d = 4'b0000;
          end else if ((cur_dir_q & bus.valid_moves) != 4'b0000) begin
            move_d = cur_dir_q;
          end else begin
            move_d = 4'b0000;
          end
        end else begin
          move_d = ($onehot(ghost_slice) && ((ghost_slice & bus.valid_moves) != 4'b0000))
                   ? ghost_slice : 4'b0000;
        end
      end
      ISSUE: begin
        if (sprite_q == 3'd4) begin
          state_d = WAIT_TICK;
        end else begin
          sprite_d = sprite_q + 3'd1;
          state_d  = SELECT;
        end
      end
      default: state_d = WAIT_TICK;
    endcase

    if (tick && (state_q != WAIT_TICK)) begin
      overrun_d = 1'b1;
    end

    // A fresh request overrides the clear done by Pacman's EVAL in the same cycle.
    if (bus.dir_req_valid && $onehot(bus.dir_req)) begin
      buf_dir_d = bus.dir_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WAIT_TICK;
      div_q     <= 24'd0;
      sprite_q  <= 3'd0;
      move_q    <= 4'b0000;
      overrun_q <= 1'b0;
      cur_dir_q <= 4'b0000;
      buf_dir_q <= 4'b0000;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      sprite_q  <= sprite_d;
      move_q    <= move_d;
      overrun_q <= overrun_d;
      cur_dir_q <= cur_dir_d;
      buf_dir_q <= buf_dir_d;
    end
  end

  assign bus.which_sprite   = sprite_q;
  assign bus.move_direction = move_q;
  assign bus.step_valid     = (state_q == ISSUE);
  assign bus.frame_overrun  = overrun_q;

endmodule

// File: tb/tb_sprite_move_scheduler.sv
// Directed bench for sprite_move_scheduler at STEP_DIV=16, plus a second instance whose
// divider period (15) is shorter than a frame, so every frame end collides with a tick.
module tb_sprite_move_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sprite_move_scheduler_if bus ();
  sprite_move_scheduler_if obus ();

`ifdef STEP_PAUSE_EN
  logic pause;
`endif

  sprite_move_scheduler #(.STEP_DIV(24'd16)) u_dut (
    .clk (clk),
    .rst (rst),
`ifdef STEP_PAUSE_EN
    .pause (pause),
`endif
    .bus (bus)
  );

  sprite_move_scheduler #(.STEP_DIV(24'd15)) u_ovr (
    .clk (clk),
    .rst (rst),
`ifdef STEP_PAUSE_EN
    .pause (1'b0),
`endif
    .bus (obus)
  );

  localparam logic [3:0] RIGHT = 4'b0001, UP = 4'b0010, DOWN = 4'b0100, LEFT = 4'b1000;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_pulse(input int idx, output logic [3:0] md);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.step_valid && t < 40);
    check($sformatf("pulse%0d_seen", idx), 32'(bus.step_valid), 32'd1);
    check($sformatf("pulse%0d_sprite", idx), 32'(bus.which_sprite), idx);
    md = bus.move_direction;
  endtask

  task automatic run_frame(input int first, output logic [19:0] md);
    logic [3:0] m;
    md = 20'h0;
    for (int i = first; i < 5; i++) begin
      wait_pulse(i, m);
      md[i*4 +: 4] = m;
    end
  endtask

  task automatic dir_pulse(input logic [3:0] d);
    bus.dir_req       = d;
    bus.dir_req_valid = 1'b1;
    @(negedge clk);
    bus.dir_req_valid = 1'b0;
    bus.dir_req       = 4'b0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_pass=%0d n_chk=%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] md;
    logic [3:0]  m;
    int np, t;

    rst = 1'b1;
    bus.dir_req = 4'b0; bus.dir_req_valid = 1'b0; bus.ghost_dirs = 16'h0; bus.valid_moves = 4'b0;
    obus.dir_req = 4'b0; obus.dir_req_valid = 1'b0; obus.ghost_dirs = 16'h0; obus.valid_moves = 4'b0;
`ifdef STEP_PAUSE_EN
    pause = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_sprite",  32'(bus.which_sprite),   32'd0);
    check("rst_move",    32'(bus.move_direction), 32'd0);
    check("rst_step",    32'(bus.step_valid),     32'd0);
    check("rst_overrun", 32'(bus.frame_overrun),  32'd0);
    check("rst_ovr_overrun", 32'(obus.frame_overrun), 32'd0);
    rst = 1'b0;

    // Frame timing: tick at cycle 15, pulses at 18,21,24,27,30; next tick at 31.
    np = 0;
    for (int n = 1; n <= 33; n++) begin
      @(negedge clk);
      if (bus.step_valid) begin
        if (np < 5) begin
          check("t_pulse_cyc", n, 18 + 3 * np);
          check("t_pulse_spr", 32'(bus.which_sprite), np);
        end
        np++;
      end
      if (n == 25) check("ovr_before_collision", 32'(obus.frame_overrun), 32'd0);
      if (n == 33) check("ovr_after_collision",  32'(obus.frame_overrun), 32'd1);
    end
    check("t_pulse_cnt", np, 5);
    run_frame(0, md);
    check("idle_frame_md", md, 20'h00000);

    // Buffered turn sequence.
    bus.valid_moves = 4'b1111;
    dir_pulse(RIGHT);
    run_frame(0, md);
    check("turn_right_md", md, 20'h00001);
    bus.valid_moves = 4'b1001;
    dir_pulse(UP);
    run_frame(0, md);
    check("continue_right_md", md, 20'h00001);
    check("buf_held_up", 32'(u_dut.buf_dir_q), 32'(UP));
    bus.valid_moves = 4'b0011;
    run_frame(0, md);
    check("take_up_md", md, 20'h00002);
    check("buf_cleared", 32'(u_dut.buf_dir_q), 32'd0);

    // Request landing in the same cycle as Pacman's EVAL clear.
    bus.valid_moves = 4'b1010;
    dir_pulse(LEFT);
    repeat (2) @(negedge clk);
    bus.dir_req = DOWN; bus.dir_req_valid = 1'b1;
    @(negedge clk);
    bus.dir_req = 4'b0; bus.dir_req_valid = 1'b0;
    check("simul_step",   32'(bus.step_valid),     32'd1);
    check("simul_sprite", 32'(bus.which_sprite),   32'd0);
    check("simul_move",   32'(bus.move_direction), 32'(LEFT));
    run_frame(1, md);
    check("buf_new_req_wins", 32'(u_dut.buf_dir_q), 32'(DOWN));

    // Continue with buffered turn still pending, then consume it.
    bus.valid_moves = 4'b1000;
    run_frame(0, md);
    check("cont_left_md", md, 20'h00008);
    check("buf_kept_down", 32'(u_dut.buf_dir_q), 32'(DOWN));
    bus.valid_moves = 4'b0100;
    run_frame(0, md);
    check("take_down_md", md, 20'h00004);
    bus.valid_moves = 4'b1000;
    dir_pulse(LEFT);
    run_frame(0, md);
    check("take_left_md", md, 20'h00008);

    // Blocked Pacman; ghosts: legal, multi-hot, illegal, legal.
    bus.valid_moves = 4'b0110;
    bus.ghost_dirs  = {4'b0100, 4'b1000, 4'b0011, 4'b0010};
    run_frame(0, md);
    check("blocked_ghost_md", md, 20'h40020);
    bus.valid_moves = 4'b1000;
    bus.ghost_dirs  = 16'h8888;
    run_frame(0, md);
    check("resume_all_left_md", md, 20'h88888);

    // Multi-hot and unqualified requests are ignored.
    bus.ghost_dirs  = 16'h0;
    bus.valid_moves = 4'b1011;
    dir_pulse(4'b0011);
    bus.dir_req = UP;
    run_frame(0, md);
    bus.dir_req = 4'b0;
    check("ignore_bad_req_md", md, 20'h00008);
    check("ignore_bad_req_buf", 32'(u_dut.buf_dir_q), 32'd0);

    // Reset in the middle of a frame.
    bus.valid_moves = 4'b1111;
    bus.ghost_dirs  = 16'h8421;
    wait_pulse(0, m);
    check("pre_rst_pac", m, LEFT);
    wait_pulse(1, m);
    check("pre_rst_blinky", m, RIGHT);
    check("ovr_sticky", 32'(obus.frame_overrun), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_step",    32'(bus.step_valid),     32'd0);
    check("mid_rst_sprite",  32'(bus.which_sprite),   32'd0);
    check("mid_rst_move",    32'(bus.move_direction), 32'd0);
    check("mid_rst_ovr_clr", 32'(obus.frame_overrun), 32'd0);
    rst = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.step_valid && t < 40);
    check("rst_first_pulse_cyc", t, 18);
    check("rst_first_sprite", 32'(bus.which_sprite), 32'd0);
    check("rst_cur_dir_cleared", 32'(bus.move_direction), 32'd0);
    run_frame(1, md);
    check("post_rst_ghosts", 32'(md[19:4]), 32'h8421);

`ifdef STEP_PAUSE_EN
    // Pause from tick+1: frame completes, then no tick until released.
    @(negedge clk);
    @(negedge clk);
    pause = 1'b1;
    run_frame(0, md);
    np = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.step_valid) np++;
    end
    check("paused_no_pulse", np, 0);
    pause = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.step_valid && t < 40);
    check("unpause_pulse_cyc", t, 18);
`endif

    check("main_no_overrun", 32'(bus.frame_overrun), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
